id_ex_stage: RTL

- ID/EX pipeline stage directly downstream of the register file.
- Latches decoded operands and control into EX with a 1-cycle latency.
- Detects load-use hazards: inserts a bubble and holds IF/ID while the hazard persists.
- Bypasses a same-cycle WB write into the captured operands, because the register file read is asynchronous and its write only lands at the clock edge.
- Handles branch flush from EX, external EX hold, and counts stall bubbles.

---
 rtl/id_ex_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB same-cycle bypass,
// branch flush, EX hold and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs_idx,
  input  logic [REG_ADDR_W-1:0] id_rt_idx,
  input  logic [REG_ADDR_W-1:0] id_rd_idx,
  input  logic                  id_uses_rt,
  input  logic [7:0]            id_ctrl,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_idx,
  input  logic [DATA_W-1:0]     wb_write_data,
  input  logic                  ex_flush,
  input  logic                  ex_hold,
  output logic                  stall_o,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs_idx,
  output logic [REG_ADDR_W-1:0] ex_rt_idx,
  output logic [REG_ADDR_W-1:0] ex_rd_idx,
  output logic [7:0]            ex_ctrl,
  output logic [CNT_W-1:0]      bubble_cnt
);

  logic                  r_valid;
  logic [DATA_W-1:0]     r_pc4;
  logic [DATA_W-1:0]     r_rs_data;
  logic [DATA_W-1:0]     r_rt_data;
  logic [DATA_W-1:0]     r_imm;
  logic [REG_ADDR_W-1:0] r_rs_idx;
  logic [REG_ADDR_W-1:0] r_rt_idx;
  logic [REG_ADDR_W-1:0] r_rd_idx;
  logic [7:0]            r_ctrl;
  logic [CNT_W-1:0]      r_bubble_cnt;

  logic                  w_hz;
  logic                  w_rs_byp;
  logic                  w_rt_byp;
  logic [DATA_W-1:0]     w_rs_val;
  logic [DATA_W-1:0]     w_rt_val;

  // A load in EX whose target feeds the ID instruction; r0 is hardwired so never a hazard.
  assign w_hz = r_valid & r_ctrl[1] & (r_rt_idx != '0) & id_valid &
                ((r_rt_idx == id_rs_idx) | (id_uses_rt & (r_rt_idx == id_rt_idx)));

  assign stall_o = ~rst & ~ex_flush & (ex_hold | w_hz);

  // The register file write lands at this edge, so its async read is still stale.
  assign w_rs_byp = wb_reg_write & (wb_write_idx != '0) & (wb_write_idx == id_rs_idx);
  assign w_rt_byp = wb_reg_write & (wb_write_idx != '0) & (wb_write_idx == id_rt_idx);
  assign w_rs_val = w_rs_byp ? wb_write_data : id_rs_data;
  assign w_rt_val = w_rt_byp ? wb_write_data : id_rt_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc4        <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs_idx     <= '0;
      r_rt_idx     <= '0;
      r_rd_idx     <= '0;
      r_ctrl       <= '0;
      r_bubble_cnt <= '0;
    end else if (ex_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (ex_hold) begin
      r_valid <= r_valid;
    end else if (w_hz) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (r_bubble_cnt != '1) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end else begin
      r_valid   <= id_valid;
      r_ctrl    <= id_valid ? id_ctrl : 8'h00;
      r_pc4     <= id_pc4;
      r_rs_data <= w_rs_val;
      r_rt_data <= w_rt_val;
      r_imm     <= id_imm;
      r_rs_idx  <= id_rs_idx;
      r_rt_idx  <= id_rt_idx;
      r_rd_idx  <= id_rd_idx;
    end
  end

  assign ex_valid   = r_valid;
  assign ex_pc4     = r_pc4;
  assign ex_rs_data = r_rs_data;
  assign ex_rt_data = r_rt_data;
  assign ex_imm     = r_imm;
  assign ex_rs_idx  = r_rs_idx;
  assign ex_rt_idx  = r_rt_idx;
  assign ex_rd_idx  = r_rd_idx;
  assign ex_ctrl    = r_ctrl;
  assign bubble_cnt = r_bubble_cnt;

endmodule
